// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one synchronous 64-bit memory port between
// core fetch and the loader/debug port, routing read data back to its requester.
module imem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,

    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic              fetch_stall_o,
    output logic              fetch_valid_o,
    output logic [DATA_W-1:0] fetch_data_o,

    input  logic              ldr_req_i,
    input  logic              ldr_we_i,
    input  logic [ADDR_W-1:0] ldr_addr_i,
    input  logic [DATA_W-1:0] ldr_wdata_i,
    output logic              ldr_gnt_o,
    output logic              ldr_valid_o,
    output logic [DATA_W-1:0] ldr_rdata_o,

    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    logic [3:0]        burst_cnt;
    logic              rsp_fetch;
    logic              rsp_ldr;
    logic [DATA_W-1:0] fetch_hold;
    logic [DATA_W-1:0] ldr_hold;

    // Loader wins contention until it has taken BURST_LIMIT grants in a row.
    always_comb begin
        fetch_gnt_o = 1'b0;
        ldr_gnt_o   = 1'b0;
        if (!reset_i) begin
            if (fetch_req_i && ldr_req_i) begin
                if (burst_cnt < BURST_LIMIT) ldr_gnt_o   = 1'b1;
                else                         fetch_gnt_o = 1'b1;
            end else if (fetch_req_i) begin
                fetch_gnt_o = 1'b1;
            end else if (ldr_req_i) begin
                ldr_gnt_o = 1'b1;
            end
        end
    end

    assign fetch_stall_o = fetch_req_i & ~fetch_gnt_o;

    assign mem_re_o    = fetch_gnt_o | (ldr_gnt_o & ~ldr_we_i);
    assign mem_we_o    = ldr_gnt_o & ldr_we_i;
    assign mem_addr_o  = ldr_gnt_o ? ldr_addr_i : fetch_addr_i;
    assign mem_wdata_o = ldr_gnt_o ? ldr_wdata_i : '0;

    // Gating with reset lets a reset in the response cycle squash that response.
    assign fetch_valid_o = rsp_fetch & ~reset_i;
    assign ldr_valid_o   = rsp_ldr & ~reset_i;
    assign fetch_data_o  = fetch_valid_o ? mem_rdata_i : fetch_hold;
    assign ldr_rdata_o   = ldr_valid_o ? mem_rdata_i : ldr_hold;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            burst_cnt  <= 4'd0;
            rsp_fetch  <= 1'b0;
            rsp_ldr    <= 1'b0;
            fetch_hold <= '0;
            ldr_hold   <= '0;
        end else begin
            rsp_fetch <= fetch_gnt_o;
            rsp_ldr   <= ldr_gnt_o & ~ldr_we_i;
            if (rsp_fetch) fetch_hold <= mem_rdata_i;
            if (rsp_ldr)   ldr_hold   <= mem_rdata_i;
            if (!fetch_req_i || fetch_gnt_o)
                burst_cnt <= 4'd0;
            else if (ldr_gnt_o)
                burst_cnt <= burst_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural synchronous memory model.
module tb_imem_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;

    logic              clk_sys = 1'b0;
    logic              reset_i;
    logic              fetch_req_i;
    logic [ADDR_W-1:0] fetch_addr_i;
    logic              fetch_gnt_o, fetch_stall_o, fetch_valid_o;
    logic [DATA_W-1:0] fetch_data_o;
    logic              ldr_req_i, ldr_we_i;
    logic [ADDR_W-1:0] ldr_addr_i;
    logic [DATA_W-1:0] ldr_wdata_i;
    logic              ldr_gnt_o, ldr_valid_o;
    logic [DATA_W-1:0] ldr_rdata_o;
    logic              mem_re_o, mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_sys = ~clk_sys;

    imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
        .clock_i      (clk_sys),
        .reset_i      (reset_i),
        .fetch_req_i  (fetch_req_i),
        .fetch_addr_i (fetch_addr_i),
        .fetch_gnt_o  (fetch_gnt_o),
        .fetch_stall_o(fetch_stall_o),
        .fetch_valid_o(fetch_valid_o),
        .fetch_data_o (fetch_data_o),
        .ldr_req_i    (ldr_req_i),
        .ldr_we_i     (ldr_we_i),
        .ldr_addr_i   (ldr_addr_i),
        .ldr_wdata_i  (ldr_wdata_i),
        .ldr_gnt_o    (ldr_gnt_o),
        .ldr_valid_o  (ldr_valid_o),
        .ldr_rdata_o  (ldr_rdata_o),
        .mem_re_o     (mem_re_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    always @(posedge clk_sys) begin
        if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
        if (mem_re_o) mem_rdata_i <= mem[mem_addr_o];
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; new inputs are then applied 1 ns after the edge.
    task automatic cycle();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = 64'(k) * 64'h0101;
        mem_rdata_i  = '0;
        reset_i      = 1'b1;
        fetch_req_i  = 1'b1;
        fetch_addr_i = '0;
        ldr_req_i    = 1'b1;
        ldr_we_i     = 1'b0;
        ldr_addr_i   = 10'h100;
        ldr_wdata_i  = '0;

        // Reset held with both requesting
        cycle();
        cycle();
        #1;
        check_val("rst_fetch_gnt", 64'(fetch_gnt_o), 64'd0);
        check_val("rst_ldr_gnt", 64'(ldr_gnt_o), 64'd0);
        check_val("rst_mem_we", 64'(mem_we_o), 64'd0);
        check_val("rst_mem_re", 64'(mem_re_o), 64'd0);
        check_val("rst_stall", 64'(fetch_stall_o), 64'd1);
        check_val("rst_fvalid", 64'(fetch_valid_o), 64'd0);
        check_val("rst_fdata", fetch_data_o, 64'd0);
        check_val("rst_lvalid", 64'(ldr_valid_o), 64'd0);
        check_val("rst_ldata", ldr_rdata_o, 64'd0);

        // Release: burst pattern L,L,L,L,F,L,L,L,L,F
        cycle();
        reset_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            logic exp_f;
            exp_f = (i == 4) || (i == 9);
            #1;
            check_val($sformatf("burst%0d_fgnt", i), 64'(fetch_gnt_o), 64'(exp_f));
            check_val($sformatf("burst%0d_lgnt", i), 64'(ldr_gnt_o), 64'(!exp_f));
            check_val($sformatf("burst%0d_stall", i), 64'(fetch_stall_o), 64'(!exp_f));
            cycle();
        end
        fetch_req_i = 1'b0;
        ldr_req_i   = 1'b0;
        cycle();

        // Fetch-only stream of addresses 0,1,2
        for (int i = 0; i < 4; i++) begin
            fetch_req_i  = (i < 3);
            fetch_addr_i = 10'(i);
            #1;
            if (i < 3) begin
                check_val($sformatf("fo%0d_gnt", i), 64'(fetch_gnt_o), 64'd1);
                check_val($sformatf("fo%0d_stall", i), 64'(fetch_stall_o), 64'd0);
            end
            if (i > 0) begin
                check_val($sformatf("fo%0d_valid", i), 64'(fetch_valid_o), 64'd1);
                check_val($sformatf("fo%0d_data", i), fetch_data_o, 64'(i - 1) * 64'h0101);
            end
            cycle();
        end
        #1;
        check_val("fo_valid_drop", 64'(fetch_valid_o), 64'd0);
        check_val("fo_data_hold", fetch_data_o, 64'h0202);

        // Loader write to 0x3FF then fetch read of it
        ldr_req_i   = 1'b1;
        ldr_we_i    = 1'b1;
        ldr_addr_i  = 10'h3FF;
        ldr_wdata_i = 64'hDEADBEEF_CAFEF00D;
        #1;
        check_val("wr_lgnt", 64'(ldr_gnt_o), 64'd1);
        check_val("wr_we", 64'(mem_we_o), 64'd1);
        check_val("wr_re", 64'(mem_re_o), 64'd0);
        cycle();
        ldr_req_i    = 1'b0;
        ldr_we_i     = 1'b0;
        fetch_req_i  = 1'b1;
        fetch_addr_i = 10'h3FF;
        #1;
        check_val("wr_we_once", 64'(mem_we_o), 64'd0);
        check_val("wr_fgnt", 64'(fetch_gnt_o), 64'd1);
        check_val("wr_lvalid0", 64'(ldr_valid_o), 64'd0);
        cycle();
        fetch_req_i = 1'b0;
        #1;
        check_val("wr_fvalid", 64'(fetch_valid_o), 64'd1);
        check_val("wr_fdata", fetch_data_o, 64'hDEADBEEF_CAFEF00D);
        check_val("wr_lvalid1", 64'(ldr_valid_o), 64'd0);
        cycle();

        // Interleaved: loader read 0x010, then fetch read 0x020
        ldr_req_i  = 1'b1;
        ldr_addr_i = 10'h010;
        #1;
        check_val("il_lgnt", 64'(ldr_gnt_o), 64'd1);
        check_val("il_re", 64'(mem_re_o), 64'd1);
        check_val("il_addr", 64'(mem_addr_o), 64'h010);
        cycle();
        ldr_req_i    = 1'b0;
        fetch_req_i  = 1'b1;
        fetch_addr_i = 10'h020;
        #1;
        check_val("il_lvalid", 64'(ldr_valid_o), 64'd1);
        check_val("il_ldata", ldr_rdata_o, 64'h1010);
        check_val("il_fgnt", 64'(fetch_gnt_o), 64'd1);
        check_val("il_addr2", 64'(mem_addr_o), 64'h020);
        cycle();
        fetch_req_i = 1'b0;
        #1;
        check_val("il_fvalid", 64'(fetch_valid_o), 64'd1);
        check_val("il_fdata", fetch_data_o, 64'h2020);
        check_val("il_lvalid_drop", 64'(ldr_valid_o), 64'd0);
        check_val("il_ldata_hold", ldr_rdata_o, 64'h1010);
        cycle();

        // Reset in the cycle after a fetch grant
        fetch_req_i  = 1'b1;
        fetch_addr_i = 10'h005;
        #1;
        check_val("rm_fgnt", 64'(fetch_gnt_o), 64'd1);
        cycle();
        fetch_req_i = 1'b0;
        reset_i     = 1'b1;
        #1;
        check_val("rm_fvalid_n1", 64'(fetch_valid_o), 64'd0);
        cycle();
        reset_i = 1'b0;
        #1;
        check_val("rm_fvalid_n2", 64'(fetch_valid_o), 64'd0);
        check_val("rm_fdata", fetch_data_o, 64'd0);
        check_val("rm_ldata", ldr_rdata_o, 64'd0);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
